fft_bfu_sched: RTL
==================

Name: fft_bfu_sched

Overview:
Sequencer for a single shared butterfly unit computing an in-place radix-2 DIT FFT of 2^N_LOG2 points held in a dual-port sample RAM. Input samples are already in bit-reversed order.
- Per butterfly, it generates the two read addresses, the twiddle index and the BFU enable.
- It delays the addresses to match the BFU latency and issues the write-back.
- It inserts a drain gap between stages to avoid read-after-write hazards.
- Sits between the top-level control (start/done) and the BFU + sample RAM + twiddle ROM.

Parameters:
N_LOG2, 3, log2 of FFT size N (N=8 default); legal range 2..10
BFU_LAT, 1, cycles from bfu_en to valid registered BFU outputs; legal range 1..4

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
start  in  1  start request; sampled only in IDLE
stall  in  1  hold-off from downstream/RAM arbitration; freezes issue
busy  out  1  high from the cycle after start is accepted until done
done  out  1  single-cycle pulse when the final write-back has completed
bfu_en  out  1  BFU compute strobe, one cycle per butterfly
rd_addr_a  out  N_LOG2  RAM read address of upper input
rd_addr_b  out  N_LOG2  RAM read address of lower input
tw_idx  out  N_LOG2-1  twiddle ROM index k for W_N^k
stage  out  $clog2(N_LOG2)  current stage number s
wr_en  out  1  RAM write strobe for both BFU outputs
wr_addr_a  out  N_LOG2  write address of BFU output 1
wr_addr_b  out  N_LOG2  write address of BFU output 2

Behaviour:
Reset (async, any state, including mid-transform):
- FSM goes to IDLE.
- All counters and delay-pipe valid bits are cleared.
- All outputs read 0.
- No write completes after rstn falls.

FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE: start=1 → ISSUE with s=0, b=0; busy rises in the next cycle.
- ISSUE: when stall=0, assert bfu_en for butterfly b and increment b. On b=N/2-1 → DRAIN.
  - When stall=1: bfu_en=0, b and s hold, and read addresses hold their values.
- DRAIN: lasts exactly BFU_LAT cycles; stall is ignored here.
  - Then, if s=N_LOG2-1 → FIN; otherwise s+1, b=0, → ISSUE.
- FIN: done=1 for one cycle, busy=0 in the same cycle → IDLE.
- start while busy, or in FIN, is ignored.

Address generation (combinational from s and b):
- span = 2^s, pos = b & (span-1), grp = b >> s.
- rd_addr_a = grp*2*span + pos; rd_addr_b = rd_addr_a + span.
- tw_idx = pos << (N_LOG2-1-s).
- Addresses and tw_idx are valid in any cycle with bfu_en=1. They are don't-care otherwise but are driven stable; never X.

Write-back:
- A BFU_LAT-deep shift register carries {valid, addr_a, addr_b}. It is loaded when bfu_en=1.
- The shift register advances every cycle regardless of stall.
- wr_en and the wr_addrs come from the tail, so the write occurs exactly BFU_LAT cycles after the corresponding bfu_en.

Timing, no stall:
- Each stage takes N/2 ISSUE cycles plus BFU_LAT DRAIN cycles.
- Total busy cycles = N_LOG2*(N/2+BFU_LAT).
- The last wr_en occurs in the final DRAIN cycle; done follows in the next cycle.

Boundary conditions:
- The first read of stage s+1 is always after the last write of stage s.
- stall asserted on the last butterfly delays the transition to DRAIN.

Test Plan:
- Reset then start pulse, N_LOG2=3, BFU_LAT=1, stall=0:
  - busy high for 15 cycles.
  - bfu_en pattern 4 on / 1 off, three times.
  - 12 wr_en pulses, each 1 cycle after its bfu_en.
  - done 1 cycle after the last wr_en.
- Address/twiddle sequence, as (a, b, tw):
  - s=0: (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - s=1: (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - s=2: (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - wr_addr_a/b equal the same pairs one cycle later.
- stall=1 for 3 cycles during s=1, b=2:
  - bfu_en=0 and addresses hold at (4,6).
  - The wr_en for b=1 still fires.
  - Total busy extends to 18 cycles.
- start re-pulsed mid-transform and during FIN → ignored; sequence and cycle count unchanged.
- rstn low during s=1 DRAIN:
  - All outputs 0 immediately, with no further wr_en.
  - A new start afterward restarts from s=0, b=0.
- BFU_LAT=3: each wr_en lags its bfu_en by 3 cycles; DRAIN = 3 cycles per stage; busy = 21 cycles.

Source files
------------

// File: rtl/fft_bfu_sched_if.sv
// Handshake and address bus between the FFT butterfly sequencer and its
// control, BFU, sample RAM and twiddle ROM.
interface fft_bfu_sched_if #(
  parameter int unsigned N_LOG2 = 3
);
  localparam int unsigned SW = $clog2(N_LOG2);

  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic              bfu_en;
  logic [N_LOG2-1:0] rd_addr_a;
  logic [N_LOG2-1:0] rd_addr_b;
  logic [N_LOG2-2:0] tw_idx;
  logic [SW-1:0]     stage;
  logic              wr_en;
  logic [N_LOG2-1:0] wr_addr_a;
  logic [N_LOG2-1:0] wr_addr_b;

  modport master (
    input  start, stall,
    output busy, done, bfu_en, rd_addr_a, rd_addr_b, tw_idx, stage,
           wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start, stall,
    input  busy, done, bfu_en, rd_addr_a, rd_addr_b, tw_idx, stage,
           wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_bfu_sched.sv
// Sequencer for one shared radix-2 DIT butterfly unit: walks stages and
// butterflies, issues reads/twiddles, and retires write-backs BFU_LAT later.
module fft_bfu_sched #(
  parameter int unsigned N_LOG2  = 3,
  parameter int unsigned BFU_LAT = 1
) (
  input  logic           clk,
  input  logic           rstn,
  fft_bfu_sched_if.master bus
);
  localparam int unsigned AW = N_LOG2;
  localparam int unsigned BW = N_LOG2 - 1;
  localparam int unsigned SW = $clog2(N_LOG2);
  localparam int unsigned CW = (BFU_LAT > 1) ? $clog2(BFU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [BW-1:0] tw;
  } rd_t;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } wb_t;

  state_t        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [BW-1:0] b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  rd_t           rd_q;
  logic          busy_q;
  logic          done_q;
  logic          bfu_en_c;
  wb_t           pipe_q [BFU_LAT];

  // Butterfly b of stage s: pair (grp*2*span + pos, +span), twiddle pos scaled to W_N.
  function automatic rd_t bfly_addr(input logic [SW-1:0] s, input logic [BW-1:0] b);
    logic [AW-1:0] bx;
    logic [AW-1:0] span;
    logic [AW-1:0] pos;
    logic [AW-1:0] base;
    rd_t           r;
    bx   = AW'(b);
    span = AW'(1) << s;
    pos  = bx & (span - AW'(1));
    base = ((bx >> s) << s) << 1;
    r.a  = base | pos;
    r.b  = base | pos | span;
    r.tw = BW'(pos << (SW'(N_LOG2 - 1) - s));
    return r;
  endfunction

  // Stall only gates issue; it never reaches the drain counter or write pipe.
  assign bfu_en_c = (state_q == ISSUE) && !bus.stall;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          s_d     = '0;
          b_d     = '0;
        end
      end
      ISSUE: begin
        if (!bus.stall) begin
          if (b_q == BW'((2 ** (N_LOG2 - 1)) - 1)) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            b_d = b_q + BW'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(BFU_LAT - 1)) begin
          if (s_q == SW'(N_LOG2 - 1)) begin
            state_d = FIN;
          end else begin
            state_d = ISSUE;
            s_d     = s_q + SW'(1);
            b_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read addresses are only refreshed for ISSUE so they stay stable elsewhere.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ISSUE) || (state_d == DRAIN);
      done_q  <= (state_d == FIN);
      if (state_d == ISSUE) begin
        rd_q <= bfly_addr(s_d, b_d);
      end
    end
  end

  // Write-back delay line; tail lines up with the BFU's registered results.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(BFU_LAT); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{v: bfu_en_c, a: rd_q.a, b: rd_q.b};
      for (int i = 1; i < int'(BFU_LAT); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bfu_en    = bfu_en_c;
  assign bus.rd_addr_a = rd_q.a;
  assign bus.rd_addr_b = rd_q.b;
  assign bus.tw_idx    = rd_q.tw;
  assign bus.stage     = s_q;
  assign bus.wr_en     = pipe_q[BFU_LAT-1].v;
  assign bus.wr_addr_a = pipe_q[BFU_LAT-1].a;
  assign bus.wr_addr_b = pipe_q[BFU_LAT-1].b;
endmodule
